// File: rtl/aes_dec_stream_adapter.sv
// Stream adapter around the combinational AES decrypt core: packs key and ciphertext words,
// waits a settle window, captures the plaintext and streams it back out as four words.
module aes_dec_stream_adapter #(
  parameter int unsigned KEY_LENGTH    = 128,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_is_key,
  output logic [0:127]          dec_cipher,
  output logic [0:KEY_LENGTH-1] dec_key,
  input  logic [0:127]          dec_plain,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic                  key_loaded,
  output logic                  busy
);

  localparam int unsigned Nk = KEY_LENGTH / 32;
  localparam int unsigned KW = $clog2(Nk);
  // Operands become visible to the core one edge after the last accept, so the settle
  // window is counted from there and the capture happens on the edge after it expires.
  localparam logic [3:0] WaitInit = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StLoad, StWait, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           kcnt_q, kcnt_d;
  logic [1:0]              ccnt_q, ccnt_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [1:0]              ocnt_q, ocnt_d;
  logic                    key_loaded_q, key_loaded_d;
  logic [0:KEY_LENGTH-1]   key_q;
  logic [0:127]            cipher_q;
  logic [0:127]            plain_q;
  logic                    key_we, cipher_we, plain_we;

  always_comb begin
    state_d      = state_q;
    kcnt_d       = kcnt_q;
    ccnt_d       = ccnt_q;
    wcnt_d       = wcnt_q;
    ocnt_d       = ocnt_q;
    key_loaded_d = key_loaded_q;
    key_we       = 1'b0;
    cipher_we    = 1'b0;
    plain_we     = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      StLoad: begin
        in_ready = in_is_key | key_loaded_q;
        if (in_valid && in_ready) begin
          if (in_is_key) begin
            key_we = 1'b1;
            if (kcnt_q == KW'(Nk - 1)) begin
              kcnt_d       = '0;
              key_loaded_d = 1'b1;
            end else begin
              kcnt_d = kcnt_q + 1'b1;
              if (kcnt_q == '0) key_loaded_d = 1'b0;
            end
          end else begin
            cipher_we = 1'b1;
            ccnt_d    = ccnt_q + 2'd1;
            if (ccnt_q == 2'd3) begin
              state_d = StWait;
              wcnt_d  = WaitInit;
            end
          end
        end
      end
      StWait: begin
        busy = 1'b1;
        if (wcnt_q == 4'd0) begin
          plain_we = 1'b1;
          ocnt_d   = 2'd0;
          state_d  = StDrain;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StDrain: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = plain_q[32*int'(ocnt_q) +: 32];
        out_last  = (ocnt_q == 2'd3);
        if (out_ready) begin
          ocnt_d = ocnt_q + 2'd1;
          if (ocnt_q == 2'd3) state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StLoad;
      kcnt_q       <= '0;
      ccnt_q       <= '0;
      wcnt_q       <= '0;
      ocnt_q       <= '0;
      key_loaded_q <= 1'b0;
      key_q        <= '0;
      cipher_q     <= '0;
      plain_q      <= '0;
    end else begin
      state_q      <= state_d;
      kcnt_q       <= kcnt_d;
      ccnt_q       <= ccnt_d;
      wcnt_q       <= wcnt_d;
      ocnt_q       <= ocnt_d;
      key_loaded_q <= key_loaded_d;
      for (int i = 0; i < int'(Nk); i++) begin
        if (key_we && kcnt_q == KW'(i)) key_q[32*i +: 32] <= in_data;
      end
      for (int i = 0; i < 4; i++) begin
        if (cipher_we && ccnt_q == 2'(i)) cipher_q[32*i +: 32] <= in_data;
      end
      if (plain_we) plain_q <= dec_plain;
    end
  end

  assign dec_cipher = cipher_q;
  assign dec_key    = key_q;
  assign key_loaded = key_loaded_q;

endmodule

// File: tb/tb_aes_dec_stream_adapter.sv
// Self-checking bench: queue-based reference model compared every cycle, directed AES vectors,
// then randomized traffic with occasional resets.
module tb_aes_dec_stream_adapter;

  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 128-bit key instance
  logic         reset_n, in_valid, in_ready, in_is_key, out_valid, out_ready, out_last;
  logic         key_loaded, busy;
  logic [31:0]  in_data, out_data;
  logic [0:127] dec_cipher, dec_key, dec_plain;

  // 256-bit key instance
  logic         b_reset_n, b_in_valid, b_in_ready, b_in_is_key, b_out_valid, b_out_ready;
  logic         b_out_last, b_key_loaded, b_busy;
  logic [31:0]  b_in_data, b_out_data;
  logic [0:127] b_dec_cipher, b_dec_plain;
  logic [0:255] b_dec_key;

  localparam logic [127:0] Key128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] Key256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] Ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Pt    = 128'h00112233445566778899aabbccddeeff;

  // Stand-in decrypt cores: exact for the reference vectors, a keyed scramble otherwise.
  function automatic logic [127:0] core128(input logic [127:0] c, input logic [127:0] k);
    if (c == Ct128 && k == Key128) return Pt;
    return c ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  function automatic logic [127:0] core256(input logic [127:0] c, input logic [255:0] k);
    if (c == Ct256 && k == Key256) return Pt;
    return c ^ k[255:128] ^ k[127:0];
  endfunction

  assign dec_plain   = core128(dec_cipher, dec_key);
  assign b_dec_plain = core256(b_dec_cipher, b_dec_key);

  aes_dec_stream_adapter #(.KEY_LENGTH(128), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_is_key(in_is_key), .dec_cipher(dec_cipher), .dec_key(dec_key), .dec_plain(dec_plain),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .key_loaded(key_loaded), .busy(busy)
  );

  aes_dec_stream_adapter #(.KEY_LENGTH(256), .SETTLE_CYCLES(S)) dut256 (
    .clk(clk), .reset_n(b_reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_is_key(b_in_is_key), .dec_cipher(b_dec_cipher),
    .dec_key(b_dec_key), .dec_plain(b_dec_plain), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .key_loaded(b_key_loaded), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: key words, partial cipher words, and a block in flight as a countdown
  // followed by a queue of plaintext words.
  logic [31:0] m_key[4];
  logic [31:0] m_ciph[4];
  int          m_kcnt, m_ccnt, m_delay;
  bit          m_kl;
  logic [31:0] m_outq[$];

  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          last_acc_cyc, first_valid_cyc;
  bit          prev_v = 1'b0;
  logic [31:0] rec[$];
  bit          rec_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : cmp
    bit          m_busy, e_valid, e_ready;
    logic [31:0] e_data;
    logic [127:0] pt;
    m_busy  = (m_delay > 0) || (m_outq.size() != 0);
    e_valid = (m_delay == 0) && (m_outq.size() != 0);
    e_ready = !m_busy && (in_is_key || m_kl);
    e_data  = e_valid ? m_outq[0] : 32'h0;
    if (chk_en) begin
      chk("in_ready", in_ready, e_ready);
      chk("out_valid", out_valid, e_valid);
      chk("out_data", out_data, e_data);
      chk("out_last", out_last, e_valid && m_outq.size() == 1);
      chk("busy", busy, m_busy);
      chk("key_loaded", key_loaded, m_kl);
      chk("dec_key", dec_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
      chk("dec_cipher", dec_cipher, {m_ciph[0], m_ciph[1], m_ciph[2], m_ciph[3]});
    end
    if (out_valid && !prev_v) first_valid_cyc = cyc;
    prev_v = out_valid;
    if (out_valid && out_ready && reset_n) begin
      rec.push_back(out_data);
      rec_last.push_back(out_last);
    end
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        m_key[i]  = '0;
        m_ciph[i] = '0;
      end
      m_kcnt = 0; m_ccnt = 0; m_delay = 0; m_kl = 1'b0;
      m_outq.delete();
    end else begin
      if (e_valid && out_ready) void'(m_outq.pop_front());
      else if (m_delay > 0) m_delay--;
      if (!m_busy && in_valid && e_ready) begin
        if (in_is_key) begin
          m_key[m_kcnt] = in_data;
          if (m_kcnt == 0) m_kl = 1'b0;
          if (m_kcnt == 3) begin m_kl = 1'b1; m_kcnt = 0; end
          else m_kcnt++;
        end else begin
          m_ciph[m_ccnt] = in_data;
          m_ccnt++;
          if (m_ccnt == 4) begin
            m_ccnt = 0;
            pt = core128({m_ciph[0], m_ciph[1], m_ciph[2], m_ciph[3]},
                         {m_key[0], m_key[1], m_key[2], m_key[3]});
            for (int i = 0; i < 4; i++) m_outq.push_back(pt[127-32*i -: 32]);
            m_delay      = S + 1;
            last_acc_cyc = cyc + 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic k);
    bit hs;
    int n = 0;
    in_valid = 1'b1; in_data = d; in_is_key = k;
    forever begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      if (hs) break;
      if (++n > 100) begin chk("send_timeout", 1, 0); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] v, input logic k);
    for (int i = 0; i < 4; i++) send(v[127-32*i -: 32], k);
  endtask

  task automatic drain(input logic [3:0] pat);
    int n = 0;
    rec.delete(); rec_last.delete();
    while (rec.size() < 4 && n < 200) begin
      out_ready = pat[n % 4];
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    chk("drain_count", rec.size(), 4);
  endtask

  task automatic check_pt(input string name);
    for (int i = 0; i < 4; i++) begin
      if (i < rec.size()) chk(name, rec[i], Pt[127-32*i -: 32]);
      else chk(name, 0, 1);
    end
  endtask

  task automatic send256(input logic [31:0] d, input logic k);
    bit hs;
    int n = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_is_key = k;
    forever begin
      @(negedge clk); hs = b_in_ready;
      @(posedge clk); #1;
      if (hs) break;
      if (++n > 100) begin chk("send256_timeout", 1, 0); break; end
    end
    b_in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] b_rec[$];
    int n;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_is_key = 1'b0; out_ready = 1'b0;
    b_reset_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_is_key = 1'b0;
    b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1; reset_n = 1'b1; b_reset_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_key_loaded", key_loaded, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;

    // Ciphertext before any key stalls
    in_valid = 1'b1; in_is_key = 1'b0; in_data = 32'h69c4e0d8;
    repeat (3) begin @(negedge clk); chk("no_key_stall", in_ready, 0); end
    @(posedge clk); #1 in_valid = 1'b0;

    // AES-128 vector, full-rate drain, latency
    send_block(Key128, 1'b1);
    @(negedge clk); chk("key_loaded_lit", key_loaded, 1);
    @(posedge clk); #1;
    send_block(Ct128, 1'b0);
    drain(4'b1111);
    check_pt("aes128_pt");
    chk("latency", first_valid_cyc - last_acc_cyc, S + 1);
    chk("last_on_4th", {rec_last[0], rec_last[3]}, 2'b01);

    // Second block, key retained, stalled drain
    send_block(Ct128, 1'b0);
    drain(4'b1001);
    check_pt("stall_pt");
    @(negedge clk); chk("ready_after_drain", in_ready, 1);
    @(posedge clk); #1;

    // Reset during WAIT
    send_block(Ct128, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_valid", out_valid, 0);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_kl", key_loaded, 0);
    chk("rst_wait_ready", in_ready, 0);
    #1 in_is_key = 1'b1;
    #1 chk("rst_wait_ready_key", in_ready, 1);
    @(posedge clk); #1;

    // Reset during DRAIN
    send_block(Key128, 1'b1);
    send_block(Ct128, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("reach_drain", out_valid, 1);
    in_is_key = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_drain_valid", out_valid, 0);
    chk("rst_drain_busy", busy, 0);
    chk("rst_drain_kl", key_loaded, 0);
    chk("rst_drain_ready", in_ready, 0);
    @(posedge clk); #1;

    // AES-256 vector on the second instance
    for (int i = 0; i < 8; i++) send256(Key256[255-32*i -: 32], 1'b1);
    for (int i = 0; i < 4; i++) send256(Ct256[127-32*i -: 32], 1'b0);
    b_out_ready = 1'b1;
    n = 0;
    while (b_rec.size() < 4 && n < 50) begin
      @(negedge clk);
      if (b_out_valid) b_rec.push_back(b_out_data);
      @(posedge clk); #1;
      n++;
    end
    b_out_ready = 1'b0;
    chk("aes256_count", b_rec.size(), 4);
    for (int i = 0; i < 4 && i < b_rec.size(); i++) chk("aes256_pt", b_rec[i], Pt[127-32*i -: 32]);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom_range(0, 199) != 0);
      in_valid  = $urandom_range(0, 1) != 0;
      in_is_key = ($urandom_range(0, 9) < 2);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
